// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit schedule word per clock, one 128-bit
// round key every fourth word, for 128/192/256-bit cipher keys.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key,
  output logic [127:0] round_key,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [255:0]  key_r;
  logic [31:0]   key_words [8];
  logic [31:0]   hist [8];
  logic [5:0]    idx;
  logic [2:0]    phase;
  logic [3:0]    nk;
  logic [5:0]    last_idx;
  logic [7:0]    rcon;
  logic          accept, gen, last_word;
  logic          in_key, rot, sub_nk8;
  logic [31:0]   w_prev, w_back, sub_in, sub_out, w_new;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, s;
    p = 8'h00;
    s = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, with 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  for (genvar g = 0; g < 8; g++) begin : g_key_words
    assign key_words[g] = key_r[255-32*g -: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && key_size != 2'd3) state_nxt = GEN;
      GEN:     if (idx == last_idx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && start && (key_size != 2'd3);
    gen       = (state == GEN);
    last_word = gen && (idx == last_idx);
  end

  // hist[0] is w[i-1], hist[Nk-1] is w[i-Nk]
  always_comb begin
    w_prev  = hist[0];
    w_back  = hist[3'(nk - 4'd1)];
    in_key  = {2'b00, nk} > idx;
    rot     = (phase == 3'd0);
    sub_nk8 = (nk == 4'd8) && (phase == 3'd4);
    sub_in  = rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = subword(sub_in);
    if (in_key)       w_new = key_words[idx[2:0]];
    else if (rot)     w_new = w_back ^ sub_out ^ {rcon, 24'h000000};
    else if (sub_nk8) w_new = w_back ^ sub_out;
    else              w_new = w_back ^ w_prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      rk_index  <= 4'd0;
      round_key <= 128'd0;
      idx       <= 6'd0;
      phase     <= 3'd0;
      rcon      <= 8'h00;
      nk        <= 4'd4;
      last_idx  <= 6'd43;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (accept) begin
        busy  <= 1'b1;
        idx   <= 6'd0;
        phase <= 3'd0;
        rcon  <= 8'h01;
        case (key_size)
          2'd1:    begin nk <= 4'd6; last_idx <= 6'd51; end
          2'd2:    begin nk <= 4'd8; last_idx <= 6'd59; end
          default: begin nk <= 4'd4; last_idx <= 6'd43; end
        endcase
      end else if (gen) begin
        idx   <= idx + 6'd1;
        phase <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
        if (!in_key && rot) rcon <= xtime(rcon);
        if (idx[1:0] == 2'd3) begin
          round_key <= {hist[2], hist[1], hist[0], w_new};
          rk_index  <= idx[5:2];
          rk_valid  <= 1'b1;
        end
        if (last_word) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  // Key copy and word window carry no reset: only control state must be cleared.
  always_ff @(posedge clk) begin
    if (accept) key_r <= key;
    if (gen) begin
      hist[0] <= w_new;
      for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys checked against
// a word-list key-schedule model built from a brute-force S-box table.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_size;
  logic [255:0] key;
  logic [127:0] round_key;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic         busy, done;

  int           n_checks = 0;
  int           n_err = 0;
  int           sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  int           model_nr;
  int           rcon_tab [11] = '{0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key_size(key_size), .key(key),
    .round_key(round_key), .rk_valid(rk_valid), .rk_index(rk_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int k = 0; k < 8; k++) begin
      if ((b >> k) & 1) p ^= a;
      a = a << 1;
      if (a & 'h100) a ^= 'h11b;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      int inv = 0;
      int s = 0;
      for (int b = 1; b < 256; b++) if (gmul(a, b) == 1) inv = b;
      for (int i = 0; i < 8; i++) begin
        int bit_v = ((inv >> i) ^ (inv >> ((i+4)%8)) ^ (inv >> ((i+5)%8)) ^
                     (inv >> ((i+6)%8)) ^ (inv >> ((i+7)%8)) ^ ('h63 >> i)) & 1;
        s |= bit_v << i;
      end
      sb[a] = s;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {8'(sb[w[31:24]]), 8'(sb[w[23:16]]), 8'(sb[w[15:8]]), 8'(sb[w[7:0]])};
  endfunction

  // Full word list per FIPS-197 KeyExpansion, then grouped into round keys.
  function automatic void model(input logic [1:0] ks, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk = (ks == 2'd0) ? 4 : (ks == 2'd1) ? 6 : 8;
    model_nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(model_nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {8'(rcon_tab[i/nk]), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= model_nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic run(input logic [1:0] ks, input logic [255:0] k, input bit pre,
                     input bit poke, input bit chain, input logic [255:0] next_key);
    int cyc = 0;
    int pulses = 0;
    int done_cyc = -1;
    bit gap = 0;
    model(ks, k);
    if (!pre) begin
      @(posedge clk); #1;
      start = 1'b1; key_size = ks; key = k;
    end
    @(posedge clk); #1;
    start = 1'b0; key = ~k; key_size = 2'd3;
    check("busy_after_accept", busy, 1);
    while (done_cyc < 0 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 9);
      if (rk_valid) begin
        check($sformatf("rk_index%0d", pulses), rk_index, pulses);
        check($sformatf("rk_time%0d", pulses), cyc, 4*(pulses+1));
        if (pulses <= model_nr) check($sformatf("rk%0d", pulses), round_key, exp_rk[pulses]);
        else check("extra_pulse", 1, 0);
        if (pulses < 15) got_rk[pulses] = round_key;
        pulses++;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
        check("valid_with_done", rk_valid, 1);
        if (chain) begin
          start = 1'b1; key_size = 2'd0; key = next_key;
        end
      end else if (!busy) gap = 1;
    end
    check("done_time", done_cyc, 4*(model_nr+1));
    check("pulse_count", pulses, model_nr+1);
    check("busy_continuous", gap, 0);
    if (!chain) begin
      @(posedge clk); #1;
      check("valid_drops", rk_valid, 0);
      check("done_drops", done, 0);
      check("rk_hold", round_key, exp_rk[model_nr]);
      check("index_hold", rk_index, model_nr);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int cnt_busy, cnt_valid;
    logic [255:0] rk_key, nkey;
    rst = 1'b1; start = 1'b0; key_size = 2'd0; key = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("reset_round_key", round_key, 0);
    check("reset_rk_valid", rk_valid, 0);
    check("reset_rk_index", rk_index, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    run(2'd0, KEY128, 0, 0, 0, '0);
    check("v128_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("v128_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("v128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(2'd1, KEY192, 0, 0, 0, '0);
    check("v192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    run(2'd2, KEY256, 0, 0, 0, '0);
    check("v256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run(2'd0, KEY128, 0, 1, 0, '0);
    check("poke_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of a 256-bit run
    @(posedge clk); #1;
    start = 1'b1; key_size = 2'd2; key = KEY256;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_round_key", round_key, 0);
    check("midrst_rk_valid", rk_valid, 0);
    check("midrst_rk_index", rk_index, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_valid = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rk_valid || busy) cnt_valid++;
    end
    check("post_reset_quiet", cnt_valid, 0);
    run(2'd0, KEY128, 0, 0, 0, '0);

    // Illegal key size held with start
    start = 1'b1; key_size = 2'd3; key = KEY256;
    cnt_busy = 0; cnt_valid = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy) cnt_busy++;
      if (rk_valid) cnt_valid++;
    end
    start = 1'b0;
    check("illegal_busy", cnt_busy, 0);
    check("illegal_valid", cnt_valid, 0);

    for (int n = 0; n < 6; n++) begin
      rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      run(2'($urandom_range(0, 2)), rk_key, 0, 0, 0, '0);
    end

    rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    nkey   = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    run(2'd2, rk_key, 0, 0, 1, nkey);
    run(2'd0, nkey, 1, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
